product_unloader_haleyorr2027: RTL
==================================

# product_unloader_haleyorr2027

Downstream stage of the 8x8 shift-add multiplier. It captures the 16-bit product when the multiplier signals completion and optionally adds it into a 24-bit running accumulator. The result is then serialised, LSB byte first, onto an 8-bit output bus under a valid/ready handshake. This lets the datapath return results over the same 8-bit width it uses for operands.

## Interface
Parameters: none (widths fixed: product 16, accumulator 24, output byte 8).

- clock  input  1  system clock; all state changes on rising edge
- reset_n  input  1  system reset; asynchronous, active-low
- done  input  1  one-cycle pulse from the multiplier controller; product valid this cycle
- product  input  16  multiplier product (unsigned)
- acc_en  input  1  sampled with done: 1 = accumulate and send 3 bytes, 0 = send product as 2 bytes
- clear_acc  input  1  synchronous clear of accumulator and sticky flags
- out_ready  input  1  consumer can accept a byte this cycle
- out_valid  output  1  out_byte holds a valid byte
- out_byte  output  8  current output byte
- busy  output  1  high while a result is held or being sent
- acc_value  output  24  current accumulator contents
- acc_ovf  output  1  sticky: accumulator add produced carry out of bit 23
- overrun  output  1  sticky: done arrived while busy; that product was dropped

## Operation
- States: IDLE, SEND. A 2-bit byte index (0..2), a 2-bit byte count (2 or 3) and a 24-bit result register.
- IDLE: busy=0, out_valid=0. On done=1:
  - acc_en=0: result = {8'h00, product}; count = 2.
  - acc_en=1: acc = acc + product, zero-extended and 25-bit wide. Bit 24 sets acc_ovf and the accumulator wraps. result = new acc; count = 3.
  - index = 0; go to SEND.
- SEND: busy=1, out_valid=1, out_byte = result[8*index+7 : 8*index].
  - A transfer occurs when out_valid && out_ready.
  - On transfer: if index == count-1, go to IDLE; otherwise index+1.
  - out_byte stays stable while out_ready=0. out_valid never drops without a transfer.
- done in SEND: product ignored, accumulator unchanged, overrun set. The current send continues.
- clear_acc (any state): acc, acc_ovf and overrun go to 0 next edge. It does not abort an in-flight send; the result register is unchanged.
- clear_acc and done with acc_en=1 in the same IDLE cycle: the clear applies first, so acc = product, result = product, and acc_ovf ends at 0.
- done with acc_en=0 never modifies acc.
- All arithmetic is unsigned. No saturation.

## Timing
- Reset (asynchronous, while reset_n=0): state IDLE, out_valid=0, out_byte=8'h00, busy=0, acc_value=0, acc_ovf=0, overrun=0, index=0.
- Reset mid-send aborts the send immediately. No bytes are emitted after release.
- done at edge n: out_valid=1 with byte 0 after edge n. acc_value updates at the same edge.
- With out_ready held high: 1 byte per cycle. A 2-byte result occupies cycles n+1..n+2; a 3-byte result occupies n+1..n+3.
- busy falls after the edge of the last transfer. A done in that same cycle is an overrun. A done in the next cycle is accepted.
- Minimum done spacing without overrun: 3 cycles (acc_en=0) or 4 cycles (acc_en=1), with out_ready=1.

## Test plan
- Reset, then done with product=16'hBEEF, acc_en=0, out_ready=1 -> bytes 8'hEF then 8'hBE on consecutive cycles; busy low after; acc_value=0.
- acc_en=1, done with 16'h00FF then 16'h0101 (spaced 5 cycles) -> first send FF,00,00; second send 00,02,00; acc_value=24'h000200.
- Backpressure: out_ready=0 for 4 cycles after done (product 16'h1234) -> out_byte holds 8'h34 with out_valid=1. Release -> 34 then 12.
- Overflow: preload acc to 24'hFFFF00 via repeated accumulates, then add 16'h0100 -> acc_value=0, acc_ovf=1. Then clear_acc -> acc_ovf=0.
- Overrun: second done one cycle after the first -> overrun=1, first result sent intact, acc unchanged by the second done. clear_acc together with done+acc_en (product 16'h0007) -> acc_value=24'h000007.
- Assert reset_n low mid-send after byte 0 of a 3-byte result -> out_valid=0 and outputs at reset values asynchronously. No further bytes after release.

Source files
------------

// File: rtl/product_unloader_haleyorr2027_if.sv
// product_unloader_haleyorr2027_if: 8-bit valid/ready byte stream carrying serialised results.
interface product_unloader_haleyorr2027_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    modport master (output out_valid, out_byte, input out_ready);
    modport slave (input out_valid, out_byte, output out_ready);
endinterface

// File: rtl/product_unloader_haleyorr2027.sv
// product_unloader_haleyorr2027: captures multiplier products, optionally accumulates, and streams results LSB byte first.
module product_unloader_haleyorr2027 (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic                                   done,
    input  logic [15:0]                            product,
    input  logic                                   acc_en,
    input  logic                                   clear_acc,
    product_unloader_haleyorr2027_if.master        out,
    output logic                                   busy,
    output logic [23:0]                            acc_value,
    output logic                                   acc_ovf,
    output logic                                   overrun
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t      state, state_d;
    logic [1:0]  idx, idx_d, cnt, cnt_d;
    logic [23:0] result, result_d, acc_d;
    logic        ovf_d, overrun_d;
    logic [24:0] sum;
    logic        xfer;
    assign busy          = state == SEND;
    assign xfer          = busy && out.out_ready;
    assign out.out_valid = busy;
    assign out.out_byte  = busy ? result[{idx, 3'b000} +: 8] : 8'h00;
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cnt_d     = cnt;
        result_d  = result;
        acc_d     = clear_acc ? 24'h0 : acc_value;
        ovf_d     = clear_acc ? 1'b0 : acc_ovf;
        overrun_d = clear_acc ? 1'b0 : overrun;
        // clear is applied before the add so a same-cycle clear+accumulate loads the product
        sum       = {1'b0, acc_d} + {9'h000, product};
        if (state == IDLE) begin
            if (done) begin
                state_d = SEND;
                idx_d   = 2'd0;
                if (acc_en) begin
                    acc_d    = sum[23:0];
                    ovf_d    = ovf_d | sum[24];
                    result_d = sum[23:0];
                    cnt_d    = 2'd3;
                end else begin
                    result_d = {8'h00, product};
                    cnt_d    = 2'd2;
                end
            end
        end else begin
            if (done) overrun_d = 1'b1;
            if (xfer) begin
                state_d = (idx == cnt - 2'd1) ? IDLE : SEND;
                idx_d   = (idx == cnt - 2'd1) ? 2'd0 : idx + 2'd1;
            end
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            cnt       <= 2'd2;
            result    <= 24'h0;
            acc_value <= 24'h0;
            acc_ovf   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            cnt       <= cnt_d;
            result    <= result_d;
            acc_value <= acc_d;
            acc_ovf   <= ovf_d;
            overrun   <= overrun_d;
        end
    end
endmodule
